// File: rtl/gpr_rank_sched.sv
// Round-robin scheduler granting NREQ requesters read-modify-write
// access to a GPR file: IDLE grants, READ fetches, WRITE commits.
module gpr_rank_sched #(
    parameter int BW    = 6,
    parameter int COUNT = 32,
    parameter int ADDR  = $clog2(COUNT),
    parameter int NREQ  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [2*NREQ-1:0]    req_op,
    input  logic [NREQ*ADDR-1:0] req_addr,
    input  logic [NREQ*BW-1:0]   req_data,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [BW-1:0]        rd_data,
    output logic                 gpr_we_n,
    output logic [ADDR-1:0]      gpr_w_addr,
    output logic [BW-1:0]        gpr_w_data,
    output logic [ADDR-1:0]      gpr_r1_addr,
    input  logic [BW-1:0]        gpr_r1_data
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_INCR  = 2'b01;
    localparam logic [1:0] OP_DECR  = 2'b10;
    localparam logic [1:0] OP_READ  = 2'b11;

    localparam logic [BW-1:0] MAXV = '1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE
    } state_t;

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [1:0]      l_op;
    logic [ADDR-1:0] l_addr;
    logic [BW-1:0]   l_data;
    logic [NREQ-1:0] l_who;
    logic            we_n_q;
    logic [NREQ-1:0] done_q;

    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] sel;
    logic [PW-1:0]   win;
    logic            found;
    logic [1:0]      s_op;
    logic [ADDR-1:0] s_addr;
    logic [BW-1:0]   s_data;
    logic [BW-1:0]   nv;

    // Round-robin pick: requests at or above ptr first, then wrap to 0.
    always_comb begin
        hi     = '0;
        sel    = '0;
        win    = '0;
        found  = 1'b0;
        s_op   = '0;
        s_addr = '0;
        s_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            hi[i] = req[i] && (i >= int'(ptr));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && hi[i]) begin
                found  = 1'b1;
                sel[i] = 1'b1;
                win    = PW'(i);
                s_op   = req_op[2*i +: 2];
                s_addr = req_addr[ADDR*i +: ADDR];
                s_data = req_data[BW*i +: BW];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                sel[i] = 1'b1;
                win    = PW'(i);
                s_op   = req_op[2*i +: 2];
                s_addr = req_addr[ADDR*i +: ADDR];
                s_data = req_data[BW*i +: BW];
            end
        end
    end

    // New GPR value from the old one; INCR/DECR saturate at the rails.
    always_comb begin
        nv = gpr_r1_data;
        unique case (l_op)
            OP_WRITE: nv = l_data;
            OP_INCR:  if (gpr_r1_data != MAXV) nv = gpr_r1_data + 1'b1;
            OP_DECR:  if (gpr_r1_data != '0) nv = gpr_r1_data - 1'b1;
            default:  nv = gpr_r1_data;
        endcase
    end

    // Reset masks the write strobe and pulses in the very cycle it rises.
    assign gnt      = (state == IDLE && !reset) ? sel : '0;
    assign done     = reset ? '0 : done_q;
    assign gpr_we_n = we_n_q | reset;

    // Scheduler FSM with registered GPR-side outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            l_op        <= '0;
            l_addr      <= '0;
            l_data      <= '0;
            l_who       <= '0;
            we_n_q      <= 1'b1;
            done_q      <= '0;
            rd_data     <= '0;
            gpr_w_addr  <= '0;
            gpr_w_data  <= '0;
            gpr_r1_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state       <= READ;
                        l_op        <= s_op;
                        l_addr      <= s_addr;
                        l_data      <= s_data;
                        l_who       <= sel;
                        gpr_r1_addr <= s_addr;
                        ptr <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    end
                end
                READ: begin
                    state      <= WRITE;
                    rd_data    <= gpr_r1_data;
                    gpr_w_addr <= l_addr;
                    gpr_w_data <= nv;
                    we_n_q     <= (l_op == OP_READ);
                    done_q     <= l_who;
                end
                WRITE: begin
                    state  <= IDLE;
                    we_n_q <= 1'b1;
                    done_q <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/gpr_rank_sched.md
GPR_RANK_SCHED -- requirements
Module: gpr_rank_sched

Interface
REQ-001 SHALL have parameter BW, default 6, GPR data width.
REQ-002 SHALL have parameter COUNT, default 32, number of GPRs.
REQ-003 SHALL have parameter ADDR, default $clog2(COUNT), GPR address width.
REQ-004 SHALL have parameter NREQ, default 4, number of requesters.
REQ-005 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port req  input  NREQ  per-requester request, held high until granted.
REQ-008 SHALL have port req_op  input  2*NREQ  per-requester op: 00 WRITE, 01 INCR, 10 DECR, 11 READ.
REQ-009 SHALL have port req_addr  input  NREQ*ADDR  per-requester target GPR index.
REQ-010 SHALL have port req_data  input  NREQ*BW  per-requester write data; WRITE only.
REQ-011 SHALL have port gnt  output  NREQ  one-hot, one-cycle accept pulse.
REQ-012 SHALL have port done  output  NREQ  one-hot, one-cycle completion pulse.
REQ-013 SHALL have port rd_data  output  BW  pre-op GPR value, valid while done is high.
REQ-014 SHALL have port gpr_we_n  output  1  GPR write enable, active-low.
REQ-015 SHALL have ports gpr_w_addr  output  ADDR  and  gpr_w_data  output  BW  GPR write address/data.
REQ-016 SHALL have ports gpr_r1_addr  output  ADDR  and  gpr_r1_data  input  BW  GPR combinational read port 1.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> WRITE -> IDLE, one state per cycle.
REQ-018 IDLE: if any req bit high, SHALL pick a winner round-robin from priority pointer ptr, pulse gnt[winner], latch winner's op/addr/data, go to READ; else stay in IDLE.
REQ-019 Round-robin: SHALL search indices ptr, ptr+1, ... mod NREQ; on grant, SHALL set ptr to (winner+1) mod NREQ.
REQ-020 READ: SHALL drive gpr_r1_addr = latched addr and register gpr_r1_data as old value.
REQ-021 WRITE: SHALL assert gpr_we_n=0 for exactly this cycle with gpr_w_addr = latched addr, except op READ, which keeps gpr_we_n=1.
REQ-022 New value: SHALL be req_data for WRITE, old+1 for INCR with saturation at 2^BW-1, old-1 for DECR with saturation at 0.
REQ-023 WRITE: SHALL pulse done[winner] and drive rd_data = old value, for all ops.
REQ-024 Latency: gnt in cycle T, gpr_r1_addr valid T+1, write and done in T+2; next grant no earlier than T+3.
REQ-025 req/op/addr/data SHALL be sampled only in the grant cycle; later changes SHALL NOT affect the op in flight.
REQ-026 req deasserted before grant SHALL be treated as withdrawn, with no gnt and no done.
REQ-027 gpr_we_n SHALL be 1 in every cycle other than the WRITE cycle of a non-READ op.
REQ-028 gnt and done SHALL never have more than one bit set, and SHALL never both be high in the same cycle.
REQ-029 Outside READ/WRITE, gpr_r1_addr, gpr_w_addr and gpr_w_data SHALL hold their last values; their values are don't-care.

Reset
REQ-030 On reset SHALL set: state IDLE, ptr 0, gnt 0, done 0, rd_data 0, gpr_we_n 1, gpr_w_addr 0, gpr_w_data 0, gpr_r1_addr 0.
REQ-031 Reset during READ or WRITE SHALL abort the op: no GPR write (gpr_we_n=1 in the reset cycle and after), no done pulse.
REQ-032 Reset SHALL have priority over any simultaneous req.

Verification
REQ-033 After reset, req=0001, op0=INCR, addr0=7, gpr_r1_data=30 -> gnt=0001 at T, gpr_we_n=0 with w_addr=7 and w_data=31 at T+2, done=0001, rd_data=30.
REQ-034 req=1111 held, all ops READ, from ptr 0 -> grants in order 0001, 0010, 0100, 1000, 0001, 3 cycles apart; gpr_we_n stays 1 throughout.
REQ-035 Saturation: INCR on old value 63 -> w_data=63; DECR on old value 0 -> w_data=0; both with gpr_we_n=0 and done pulsed.
REQ-036 WRITE op, req_data=5 for addr 11, requester changes req_data to 9 at T+1 -> w_data=5 at T+2.
REQ-037 Reset asserted at T+1 of a WRITE op -> no gpr_we_n=0 cycle, no done, ptr=0 after reset.
REQ-038 req=0100 raised for one cycle while FSM is in READ, then dropped -> no gnt[2] and no done[2].
